pc_fetch_unit: RTL
==================

# pc_fetch_unit

Sequential instruction-fetch front end that consumes the branch decision (`branch_out`) and branch target, and maintains the program counter. It issues one instruction-memory request at a time over a valid/ready request channel, accepts the returned instruction word, and presents it downstream with its PC. At consume time it selects the next PC as either PC+4 or the branch target. A taken branch to a misaligned target halts fetch.

## Interface
- `XLEN`, 64, width of PC, target and memory address
- `RESET_PC`, 64'h0, PC value loaded on reset
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low; one clock, no other clock domains
- `branch_out`  in  1  taken decision for the instruction being consumed; sampled only on consume
- `branch_target`  in  XLEN  branch destination; sampled only on consume with `branch_out`=1
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_addr`  out  XLEN  fetch address (current PC)
- `imem_rsp_valid`  in  1  instruction word returned
- `imem_rsp_data`  in  32  returned instruction word
- `instr_valid`  out  1  `instr`/`instr_pc` valid downstream
- `instr`  out  32  held instruction word
- `instr_pc`  out  XLEN  PC of `instr`
- `instr_ready`  in  1  downstream consumes instruction this cycle
- `instr_count`  out  32  number of consumed instructions, wraps
- `misaligned_fault`  out  1  taken branch to target with [1:0]≠0; sticky

## Operation
- States: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE: entered on reset. Moves unconditionally to REQ on the first clock edge after reset deasserts.
- REQ: `imem_req_valid`=1, `imem_addr`=PC.
  - When `imem_req_ready`=1 → WAIT.
  - `imem_addr` stays stable while valid and not ready.
  - `imem_rsp_valid` is ignored in this state.
- WAIT: `imem_req_valid`=0.
  - When `imem_rsp_valid`=1: capture `imem_rsp_data` into `instr` and PC into `instr_pc` → HOLD.
- HOLD: `instr_valid`=1; `instr` and `instr_pc` stay stable. Consume = `instr_valid` && `instr_ready`. On consume:
  - `instr_count` increments.
  - If `branch_out`=0: PC ← PC+4, → REQ.
  - If `branch_out`=1 and `branch_target`[1:0]=0: PC ← `branch_target`, → REQ.
  - If `branch_out`=1 and `branch_target`[1:0]≠0: PC ← `branch_target`, `misaligned_fault` ← 1, → FAULT.
- FAULT: `imem_req_valid`=0, `instr_valid`=0, `imem_addr` shows the faulting target. Exit only by reset.
- Arithmetic:
  - PC+4 is modulo 2^XLEN; PC = 2^XLEN−4 wraps to 0.
  - `instr_count` wraps from 0xFFFFFFFF to 0.
- `branch_out` and `branch_target` are don't-care whenever no consume occurs.

## Timing
- Reset (async, immediate), state IDLE:
  - PC = `RESET_PC`
  - `imem_req_valid` = 0, `instr_valid` = 0, `misaligned_fault` = 0
  - `instr` = 0, `instr_pc` = 0, `instr_count` = 0
  - `imem_addr` = `RESET_PC`
- All outputs are registered or decoded from the state register; no combinational path from inputs to outputs.
- First request: `imem_req_valid` rises in the cycle after the first post-reset edge.
- Minimum loop latency, when ready and response each arrive in the first eligible cycle:
  - consume edge N → REQ during cycle N+1 → WAIT during N+2 → `instr_valid` during N+3.
  - One instruction in flight at most.
- Memory may hold `imem_req_ready` low or delay `imem_rsp_valid` indefinitely; the unit waits with no timeout.
- Reset asserted mid-request or mid-wait: `imem_req_valid` drops immediately. A `imem_rsp_valid` arriving afterwards in IDLE or REQ is ignored.
- `instr_ready` while `instr_valid`=0 has no effect.

## Test plan
- Reset with `RESET_PC`=0x1000, ready/rsp always 1 → `imem_addr` sequence 0x1000, 0x1004, 0x1008 on successive requests. First `instr_valid` 3 cycles after reset release; `instr_count` increments per consume.
- Consume at PC 0x1008 with `branch_out`=1, target 0x2000 → next `imem_addr`=0x2000 and `instr_pc`=0x2000. `branch_out`=1 presented without `instr_ready` → no effect.
- `imem_req_ready` held low 5 cycles, then `imem_rsp_valid` delayed 4 cycles → `imem_addr` stable throughout, exactly one capture. A stray `imem_rsp_valid` during REQ is ignored.
- Consume with `branch_out`=1, target 0x2002 → `misaligned_fault`=1 next cycle, `imem_addr`=0x2002, no further requests. Only reset clears the fault.
- `RESET_PC`=0xFFFF_FFFF_FFFF_FFFC, no branch → second fetch address 0x0. Preload 0xFFFFFFFF consumes → `instr_count` returns to 0.
- Reset asserted during WAIT, then `imem_rsp_valid`=1 asserted → all outputs at reset values, response ignored, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: single-outstanding instruction fetch front end.
// Tracks the PC, fetches over valid/ready and hands words downstream.
module pc_fetch_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branch_out,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  output logic [31:0]     instr_count,
  output logic            misaligned_fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic [31:0]     count_q, count_d;
  logic            fault_q, fault_d;

  // Next-state, PC selection and capture of the returned word
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    count_d    = count_q;
    fault_d    = fault_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          instr_d    = imem_rsp_data;
          instr_pc_d = pc_q;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          count_d = count_q + 32'd1;
          if (!branch_out) begin
            pc_d    = pc_q + PC_STEP;
            state_d = S_REQ;
          end else if (branch_target[1:0] == 2'b00) begin
            pc_d    = branch_target;
            state_d = S_REQ;
          end else begin
            pc_d    = branch_target;
            fault_d = 1'b1;
            state_d = S_FAULT;
          end
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      count_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      count_q    <= count_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_req_valid   = (state_q == S_REQ);
  assign imem_addr        = pc_q;
  assign instr_valid      = (state_q == S_HOLD);
  assign instr            = instr_q;
  assign instr_pc         = instr_pc_q;
  assign instr_count      = count_q;
  assign misaligned_fault = fault_q;

endmodule
